freelist_ctrl: RTL and testbench
================================

Name: freelist_ctrl

Overview:
Pointer and handshake controller for the physical-register free list RAM, which is a circular queue of free physical tags. On the dispatch side it grants up to DISPATCH_WIDTH tag allocations per cycle and drives the RAM read addresses. On the commit side it compacts up to COMMIT_WIDTH released tags and drives the RAM write ports. Tracks head, tail and occupancy, and restores the free list in one cycle on pipeline recovery.

Parameters:
DEPTH, 96, free-list entries (physical regs minus architectural regs); also the reset occupancy
INDEX, 7, log2 ceiling of DEPTH; pointer width
WIDTH, 7, physical register tag width
DISPATCH_WIDTH, 4, allocation lanes
COMMIT_WIDTH, 4, release lanes

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
allocValid_i  in  1  dispatch bundle present
allocMask_i  in  DISPATCH_WIDTH  lanes needing a destination tag
allocGrant_o  out  1  bundle allocated this cycle
freeTag_o  out  DISPATCH_WIDTH*WIDTH  allocated tag per lane; valid only where mask=1 and grant=1
ramRdAddr_o  out  DISPATCH_WIDTH*INDEX  RAM read address per lane
ramRdData_i  in  DISPATCH_WIDTH*WIDTH  RAM combinational read data per lane
relValid_i  in  COMMIT_WIDTH  commit lane frees an old mapping
relTag_i  in  COMMIT_WIDTH*WIDTH  tag being freed
ramWe_o  out  COMMIT_WIDTH  RAM write enables, compacted from lane 0
ramWrAddr_o  out  COMMIT_WIDTH*INDEX  RAM write addresses
ramWrData_o  out  COMMIT_WIDTH*WIDTH  RAM write data
recover_i  in  1  flush: all in-flight allocations return to the free list
freeCount_o  out  INDEX+1  registered occupancy
overflow_o  out  1  sticky error flag

Behaviour:
- Reset (asynchronous): head=0, tail=0, count=DEPTH, overflow_o=0.
  - Outputs are combinational from state and inputs, so allocGrant_o=0 and ramWe_o=0 whenever inputs are idle.
  - The RAM powers up holding sequential tags; this block does not initialise it.
- Read addressing:
  - n_a = popcount(allocMask_i).
  - Lane i address = (head + popcount(allocMask_i[i-1:0])) mod DEPTH.
  - Unmasked lanes carry the next lane's address; that value is don't-care.
  - freeTag_o[i] = ramRdData_i[i], same cycle (zero latency).
- Grant:
  - allocGrant_o = allocValid_i & ~recover_i & (n_a <= count).
  - A bundle with n_a=0 is granted.
  - Grant is all-or-nothing: no partial bundles.
  - Grant is based on the registered count only; releases in the same cycle do not help.
- Release compaction:
  - Valid lanes map in lane order to slots 0..n_r-1, where n_r = popcount(relValid_i).
  - Slot k: we=1, addr=(tail+k) mod DEPTH, data=tag of the k-th valid lane.
  - Slots at or above n_r: we=0.
- Pointer update on posedge:
  - tail' = (tail + n_r) mod DEPTH.
  - head' = (head + (grant ? n_a : 0)) mod DEPTH.
  - count' = count + n_r - (grant ? n_a : 0).
  - Wrap is done by compare-and-subtract, not power-of-two masking, since DEPTH is arbitrary.
- Recovery (recover_i=1):
  - Releases still write and advance tail.
  - Then head' = tail', count' = DEPTH.
  - Correct because the entries in [tail, head) are exactly the in-flight allocated tags, in order.
- Overflow:
  - Triggered if count + n_r - n_granted > DEPTH.
  - Sets overflow_o sticky until reset.
  - count saturates at DEPTH; writes still occur.
- Simultaneous allocation and release with count=0: no grant; releases land and count'=n_r.

Decomposition:
- Shared package freelist_pkg: tag and pointer typedefs, DEPTH/width constants derived from the existing SIZE_RMT / physical-register-file defines, and a ptr_add(ptr, inc) wrap function.
- One sub-module, lane_compact: a parameterised prefix-popcount plus compaction network. It is instantiated once for the release side (data compaction) and reused for the allocation-side offsets.

Test Plan:
- Reset, then allocValid=1, mask=4'b1011 → grant=1; read addresses 0,1,(x),2; freeTag lanes 0,1,3 = RAM[0..2]; next cycle freeCount=93, head=3.
- count=2, mask=4'b0111 → grant=0; head and count unchanged; same bundle with relValid=4'b0101 → still no grant, count'=4.
- tail=94, relValid=4'b1110 with tags 10,11,12 → writes to addresses 94,95,0 with data 10,11,12; ramWe=4'b0111; tail'=1.
- head=95, mask=4'b1111, count≥4 → read addresses 95,0,1,2; head'=3.
- 20 tags allocated, 5 released, then recover_i together with relValid=4'b0011 → tail'=tail+2, head'=tail', freeCount=96; grant forced 0 that cycle.
- Release 1 tag at count=96 → overflow_o=1 and held; count stays 96; assert reset mid-stream → all state returns to reset values asynchronously.

Source files
------------

// File: rtl/freelist_pkg.sv
// Shared types, sizes and the modular pointer helper for the physical-register free list.
package freelist_pkg;

    localparam int PHY_REG_NUM    = 128;
    localparam int SIZE_RMT       = 32;
    localparam int DEPTH          = PHY_REG_NUM - SIZE_RMT;
    localparam int INDEX          = $clog2(DEPTH);
    localparam int WIDTH          = $clog2(PHY_REG_NUM);
    localparam int DISPATCH_WIDTH = 4;
    localparam int COMMIT_WIDTH   = 4;

    typedef logic [WIDTH-1:0] tag_t;
    typedef logic [INDEX-1:0] ptr_t;
    typedef logic [INDEX:0]   cnt_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    // DEPTH is not a power of two, so wrap with a single compare-and-subtract (inc < DEPTH).
    function automatic ptr_t ptr_add(input ptr_t ptr, input ptr_t inc);
        cnt_t sum_s;
        sum_s = {1'b0, ptr} + {1'b0, inc};
        if (sum_s >= DEPTH_CNT) begin
            sum_s = sum_s - DEPTH_CNT;
        end else begin
            sum_s = sum_s;
        end
        return sum_s[INDEX-1:0];
    endfunction

endpackage

// File: rtl/lane_compact.sv
// Exclusive prefix popcount over a lane mask, plus compaction of valid lanes' data toward slot 0.
module lane_compact #(
    parameter  int LANES = 4,
    parameter  int DW    = 7,
    localparam int CW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]    valid,
    input  logic [LANES*DW-1:0] data,
    output logic [LANES*CW-1:0] prefix,
    output logic [CW-1:0]       total,
    output logic [LANES-1:0]    comp_valid,
    output logic [LANES*DW-1:0] comp_data
);

    logic [CW-1:0] run_s;

    // Number of valid lanes strictly below each lane, and the overall count.
    always_comb begin
        run_s  = {CW{1'b0}};
        prefix = {(LANES*CW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            prefix[i*CW +: CW] = run_s;
            run_s              = run_s + CW'(valid[i]);
        end
        total = run_s;
    end

    // Lane i lands in slot prefix[i] when valid; slots are filled contiguously from 0.
    always_comb begin
        comp_valid = {LANES{1'b0}};
        comp_data  = {(LANES*DW){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < LANES; i++) begin
                comp_valid[k]         = comp_valid[k] |
                                        (valid[i] & (prefix[i*CW +: CW] == CW'(k)));
                comp_data[k*DW +: DW] = comp_data[k*DW +: DW] |
                                        (data[i*DW +: DW] &
                                         {DW{valid[i] & (prefix[i*CW +: CW] == CW'(k))}});
            end
        end
    end

endmodule

// File: rtl/freelist_ctrl.sv
// Free-list pointer/handshake controller: all-or-nothing dispatch allocation, compacted commit
// release, occupancy tracking, sticky overflow and single-cycle restore on recovery.
module freelist_ctrl
    import freelist_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            allocValid_i,
    input  logic [DISPATCH_WIDTH-1:0]       allocMask_i,
    output logic                            allocGrant_o,
    output logic [DISPATCH_WIDTH*WIDTH-1:0] freeTag_o,
    output logic [DISPATCH_WIDTH*INDEX-1:0] ramRdAddr_o,
    input  logic [DISPATCH_WIDTH*WIDTH-1:0] ramRdData_i,
    input  logic [COMMIT_WIDTH-1:0]         relValid_i,
    input  logic [COMMIT_WIDTH*WIDTH-1:0]   relTag_i,
    output logic [COMMIT_WIDTH-1:0]         ramWe_o,
    output logic [COMMIT_WIDTH*INDEX-1:0]   ramWrAddr_o,
    output logic [COMMIT_WIDTH*WIDTH-1:0]   ramWrData_o,
    input  logic                            recover_i,
    output logic [INDEX:0]                  freeCount_o,
    output logic                            overflow_o
);

    localparam int ACW = $clog2(DISPATCH_WIDTH + 1);
    localparam int RCW = $clog2(COMMIT_WIDTH + 1);

    typedef logic [INDEX+1:0] sum_t;

    ptr_t  head_r, tail_r, head_n_s, tail_n_s;
    cnt_t  count_r, count_n_s;
    logic  overflow_r;
    sum_t  sum_s;
    logic  ovf_s;

    logic [DISPATCH_WIDTH*ACW-1:0] alloc_off_s;
    logic [ACW-1:0]                n_alloc_s, n_grant_s;
    logic [DISPATCH_WIDTH-1:0]     unused_alloc_valid_s, unused_alloc_data_s;
    logic [COMMIT_WIDTH*RCW-1:0]   unused_rel_off_s;
    logic [RCW-1:0]                n_rel_s;

    lane_compact #(.LANES(DISPATCH_WIDTH), .DW(1)) u_alloc_offs (
        .valid      (allocMask_i),
        .data       ({DISPATCH_WIDTH{1'b0}}),
        .prefix     (alloc_off_s),
        .total      (n_alloc_s),
        .comp_valid (unused_alloc_valid_s),
        .comp_data  (unused_alloc_data_s)
    );

    lane_compact #(.LANES(COMMIT_WIDTH), .DW(WIDTH)) u_rel_compact (
        .valid      (relValid_i),
        .data       (relTag_i),
        .prefix     (unused_rel_off_s),
        .total      (n_rel_s),
        .comp_valid (ramWe_o),
        .comp_data  (ramWrData_o)
    );

    // Grant sees only the registered count; same-cycle releases cannot rescue a short list.
    assign allocGrant_o = allocValid_i & ~recover_i & (cnt_t'(n_alloc_s) <= count_r);
    assign n_grant_s    = allocGrant_o ? n_alloc_s : {ACW{1'b0}};
    assign freeTag_o    = ramRdData_i;
    assign freeCount_o  = count_r;
    assign overflow_o   = overflow_r;

    // Per-lane RAM read and write addresses relative to head and tail.
    always_comb begin
        ramRdAddr_o = {(DISPATCH_WIDTH*INDEX){1'b0}};
        ramWrAddr_o = {(COMMIT_WIDTH*INDEX){1'b0}};
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            ramRdAddr_o[i*INDEX +: INDEX] = ptr_add(head_r, ptr_t'(alloc_off_s[i*ACW +: ACW]));
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            ramWrAddr_o[k*INDEX +: INDEX] = ptr_add(tail_r, ptr_t'(k));
        end
    end

    assign sum_s = sum_t'(count_r) + sum_t'(n_rel_s) - sum_t'(n_grant_s);
    assign ovf_s = sum_s > sum_t'(DEPTH);

    // Next pointers/occupancy; recovery reclaims every in-flight tag by snapping head to tail.
    always_comb begin
        tail_n_s  = ptr_add(tail_r, ptr_t'(n_rel_s));
        head_n_s  = head_r;
        count_n_s = count_r;
        if (recover_i) begin
            head_n_s  = tail_n_s;
            count_n_s = DEPTH_CNT;
        end else if (ovf_s) begin
            head_n_s  = ptr_add(head_r, ptr_t'(n_grant_s));
            count_n_s = DEPTH_CNT;
        end else begin
            head_n_s  = ptr_add(head_r, ptr_t'(n_grant_s));
            count_n_s = sum_s[INDEX:0];
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r     <= {INDEX{1'b0}};
            tail_r     <= {INDEX{1'b0}};
            count_r    <= DEPTH_CNT;
            overflow_r <= 1'b0;
        end else begin
            head_r     <= head_n_s;
            tail_r     <= tail_n_s;
            count_r    <= count_n_s;
            overflow_r <= overflow_r | ovf_s;
        end
    end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Self-checking bench for freelist_ctrl: queue-level model compared every cycle plus directed literals.
module tb_freelist_ctrl;
    import freelist_pkg::*;

    localparam int D = 96;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [3:0]  alloc_mask  = 4'b0000;
    logic [3:0]  rel_valid   = 4'b0000;
    logic [27:0] rel_tag     = 28'd0;
    logic        recover     = 1'b0;
    logic        grant;
    logic [27:0] free_tag, rd_addr, rd_data, wr_addr, wr_data;
    logic [3:0]  we;
    logic [7:0]  free_count;
    logic        overflow;

    logic [6:0]  ram [D];
    bit          ram_ready = 1'b0;
    int          m_head = 0, m_tail = 0, m_count = D;
    bit          m_ovf = 1'b0;
    int          checks = 0, failures = 0;

    int          u_na, u_nr, u_ng, u_tot, u_j, u_tail;
    int          c_k, c_j, c_addr;
    logic [3:0]  c_we;

    always #5 clk = ~clk;

    freelist_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .allocValid_i (alloc_valid),
        .allocMask_i  (alloc_mask),
        .allocGrant_o (grant),
        .freeTag_o    (free_tag),
        .ramRdAddr_o  (rd_addr),
        .ramRdData_i  (rd_data),
        .relValid_i   (rel_valid),
        .relTag_i     (rel_tag),
        .ramWe_o      (we),
        .ramWrAddr_o  (wr_addr),
        .ramWrData_o  (wr_data),
        .recover_i    (recover),
        .freeCount_o  (free_count),
        .overflow_o   (overflow)
    );

    function automatic int popcnt(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    function automatic logic [6:0] lane(input logic [27:0] v, input int i);
        return v[i*7 +: 7];
    endfunction

    function automatic bit exp_grant();
        return alloc_valid && !recover && (popcnt(alloc_mask) <= m_count);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // External RAM: combinational read.
    always_comb begin
        rd_data = 28'd0;
        for (int i = 0; i < 4; i++) begin
            rd_data[i*7 +: 7] = (lane(rd_addr, i) < 7'd96) ? ram[int'(lane(rd_addr, i))] : 7'h7f;
        end
    end

    // Reference model: circular free list with plain modular arithmetic; also owns the RAM contents.
    always @(posedge clk or posedge reset) begin
        if (!ram_ready) begin
            for (int i = 0; i < D; i++) ram[i] <= 7'(i);
            ram_ready <= 1'b1;
        end
        if (reset) begin
            m_head  <= 0;
            m_tail  <= 0;
            m_count <= D;
            m_ovf   <= 1'b0;
        end else begin
            u_na = popcnt(alloc_mask);
            u_nr = popcnt(rel_valid);
            u_ng = exp_grant() ? u_na : 0;
            u_j  = 0;
            for (int i = 0; i < 4; i++) begin
                if (rel_valid[i]) begin
                    ram[(m_tail + u_j) % D] <= lane(rel_tag, i);
                    u_j++;
                end
            end
            u_tail = (m_tail + u_nr) % D;
            u_tot  = m_count + u_nr - u_ng;
            m_tail <= u_tail;
            if (u_tot > D) m_ovf <= 1'b1;
            if (recover) begin
                m_head  <= u_tail;
                m_count <= D;
            end else begin
                m_head  <= (m_head + u_ng) % D;
                m_count <= (u_tot > D) ? D : u_tot;
            end
        end
    end

    // Every-cycle comparison of all meaningful outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("grant", grant, exp_grant());
            chk("free_count", free_count, m_count);
            chk("overflow", overflow, m_ovf);
            c_k = 0;
            for (int i = 0; i < 4; i++) begin
                if (alloc_mask[i]) begin
                    c_addr = (m_head + c_k) % D;
                    chk($sformatf("rd_addr[%0d]", i), lane(rd_addr, i), c_addr);
                    if (exp_grant()) chk($sformatf("free_tag[%0d]", i), lane(free_tag, i), ram[c_addr]);
                    c_k++;
                end
            end
            c_we = 4'b0000;
            c_j  = 0;
            for (int i = 0; i < 4; i++) begin
                if (rel_valid[i]) begin
                    c_we[c_j] = 1'b1;
                    chk($sformatf("wr_addr[%0d]", c_j), lane(wr_addr, c_j), (m_tail + c_j) % D);
                    chk($sformatf("wr_data[%0d]", c_j), lane(wr_data, c_j), lane(rel_tag, i));
                    c_j++;
                end
            end
            chk("ram_we", we, c_we);
        end
    end

    task automatic step(input logic av, input logic [3:0] m, input logic [3:0] rv,
                        input logic [27:0] tags, input logic rec);
        @(posedge clk);
        #1;
        alloc_valid = av;
        alloc_mask  = m;
        rel_valid   = rv;
        rel_tag     = tags;
        recover     = rec;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 4'b0000, 28'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_count", free_count, 96);
        chk("reset_ovf", overflow, 0);
        chk("idle_grant", grant, 0);
        chk("idle_we", we, 0);

        // First bundle from a full list: lanes 0,1,3 read RAM[0..2].
        step(1'b1, 4'b1011, 4'b0000, 28'd0, 1'b0);
        chk("a_grant", grant, 1);
        chk("a_addr0", lane(rd_addr, 0), 0);
        chk("a_addr1", lane(rd_addr, 1), 1);
        chk("a_addr3", lane(rd_addr, 3), 2);
        chk("a_tag0", lane(free_tag, 0), 0);
        chk("a_tag1", lane(free_tag, 1), 1);
        chk("a_tag3", lane(free_tag, 3), 2);
        idle();
        chk("a_count", free_count, 93);
        chk("a_head", lane(rd_addr, 0), 3);

        // Drain to two free entries.
        repeat (22) step(1'b1, 4'b1111, 4'b0000, 28'd0, 1'b0);
        step(1'b1, 4'b0111, 4'b0000, 28'd0, 1'b0);
        idle();
        chk("c_count", free_count, 2);
        chk("c_head", lane(rd_addr, 0), 94);
        step(1'b1, 4'b0111, 4'b0000, 28'd0, 1'b0);
        chk("c_nogrant", grant, 0);
        step(1'b1, 4'b0111, 4'b0101, {7'd0, 7'd51, 7'd0, 7'd50}, 1'b0);
        chk("c_nogrant_rel", grant, 0);
        chk("c_we", we, 4'b0011);
        idle();
        chk("c_count2", free_count, 4);

        // Head to 95, then a wrapping 4-wide read.
        step(1'b1, 4'b0001, 4'b0001, {21'd0, 7'd60}, 1'b0);
        chk("d_addr94", lane(rd_addr, 0), 94);
        step(1'b1, 4'b1111, 4'b1111, {7'd64, 7'd63, 7'd62, 7'd61}, 1'b0);
        chk("d_grant", grant, 1);
        chk("d_addr0", lane(rd_addr, 0), 95);
        chk("d_addr1", lane(rd_addr, 1), 0);
        chk("d_addr2", lane(rd_addr, 2), 1);
        chk("d_addr3", lane(rd_addr, 3), 2);
        step(1'b1, 4'b1111, 4'b1111, {7'd68, 7'd67, 7'd66, 7'd65}, 1'b0);
        chk("d_head3", lane(rd_addr, 0), 3);
        for (int r = 0; r < 20; r++) begin
            step(1'b1, 4'b1111, 4'b1111, {4{7'(r + 70)}}, 1'b0);
        end
        step(1'b1, 4'b0001, 4'b0111, {7'd0, 7'd92, 7'd91, 7'd90}, 1'b0);
        chk("d_head87", lane(rd_addr, 0), 87);

        // Release compaction across the tail wrap (tail=94).
        step(1'b0, 4'b0000, 4'b1110, {7'd12, 7'd11, 7'd10, 7'd0}, 1'b0);
        chk("e_we", we, 4'b0111);
        chk("e_waddr0", lane(wr_addr, 0), 94);
        chk("e_waddr1", lane(wr_addr, 1), 95);
        chk("e_waddr2", lane(wr_addr, 2), 0);
        chk("e_wdata0", lane(wr_data, 0), 10);
        chk("e_wdata1", lane(wr_data, 1), 11);
        chk("e_wdata2", lane(wr_data, 2), 12);
        step(1'b0, 4'b0000, 4'b0001, {21'd0, 7'd20}, 1'b0);
        chk("e_tail1", lane(wr_addr, 0), 1);
        chk("e_count", free_count, 9);

        // Recovery after 20 allocations and 5 releases.
        @(posedge clk);
        #1;
        alloc_valid = 1'b0; alloc_mask = 4'b0000; rel_valid = 4'b0000; recover = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("f_reset_count", free_count, 96);
        repeat (5) step(1'b1, 4'b1111, 4'b0000, 28'd0, 1'b0);
        step(1'b0, 4'b0000, 4'b1111, {7'd33, 7'd32, 7'd31, 7'd30}, 1'b0);
        chk("f_count76", free_count, 76);
        step(1'b0, 4'b0000, 4'b0001, {21'd0, 7'd34}, 1'b0);
        step(1'b1, 4'b1111, 4'b0011, {7'd0, 7'd0, 7'd36, 7'd35}, 1'b1);
        chk("f_rec_grant", grant, 0);
        chk("f_rec_we", we, 4'b0011);
        chk("f_rec_waddr0", lane(wr_addr, 0), 5);
        chk("f_rec_waddr1", lane(wr_addr, 1), 6);
        chk("f_rec_count", free_count, 81);
        idle();
        chk("f_count96", free_count, 96);
        chk("f_head7", lane(rd_addr, 0), 7);

        // Overflow is sticky; writes still happen; count saturates.
        step(1'b0, 4'b0000, 4'b0001, {21'd0, 7'd40}, 1'b0);
        chk("g_we", we, 4'b0001);
        idle();
        chk("g_ovf", overflow, 1);
        chk("g_count", free_count, 96);
        repeat (3) idle();
        chk("g_ovf_held", overflow, 1);
        step(1'b1, 4'b1111, 4'b0000, 28'd0, 1'b0);
        idle();
        chk("g_count92", free_count, 92);
        chk("g_head11", lane(rd_addr, 0), 11);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        chk("h_async_count", free_count, 96);
        chk("h_async_ovf", overflow, 0);
        chk("h_async_head", lane(rd_addr, 0), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("h_post_count", free_count, 96);
        chk("h_post_ovf", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
